// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage: captures one md op per accepted start,
// holds busy for a fixed latency, then commits the result to HI/LO.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_state
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_N < 2) ? 1 : $clog2(MAX_N);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   temp_hi;
  logic [31:0]   temp_lo;
  logic          temp_we;

  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] safe_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign accept = start & ~flush & (state == IDLE);

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Divisor forced to 1 on zero so the dividers never see 0; that result is never committed.
  assign safe_b = (src_b == 32'd0) ? 32'd1 : src_b;
  assign abs_a  = src_a[31]  ? (~src_a + 32'd1)  : src_a;
  assign abs_b  = safe_b[31] ? (~safe_b + 32'd1) : safe_b;
  assign q_mag  = abs_a / abs_b;
  assign r_mag  = abs_a % abs_b;
  // Magnitude divide then re-sign: truncation toward zero, remainder follows the dividend,
  // and 0x80000000 / -1 naturally wraps to 0x80000000 with remainder 0.
  assign q_s    = (src_a[31] ^ safe_b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = src_a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = src_a / safe_b;
  assign r_u    = src_a % safe_b;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      temp_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (md_op)
              3'd0: begin
                state   <= RUN;
                busy    <= 1'b1;
                count   <= MULT_LOAD;
                temp_hi <= prod_s[63:32];
                temp_lo <= prod_s[31:0];
                temp_we <= 1'b1;
              end
              3'd1: begin
                state   <= RUN;
                busy    <= 1'b1;
                count   <= MULT_LOAD;
                temp_hi <= prod_u[63:32];
                temp_lo <= prod_u[31:0];
                temp_we <= 1'b1;
              end
              3'd2: begin
                state   <= RUN;
                busy    <= 1'b1;
                count   <= DIV_LOAD;
                temp_hi <= r_s;
                temp_lo <= q_s;
                temp_we <= (src_b != 32'd0);
              end
              3'd3: begin
                state   <= RUN;
                busy    <= 1'b1;
                count   <= DIV_LOAD;
                temp_hi <= r_u;
                temp_lo <= q_u;
                temp_we <= (src_b != 32'd0);
              end
              3'd4:    hi <= src_a;
              3'd5:    lo <= src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (count == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (temp_we) begin
              hi <= temp_hi;
              lo <= temp_lo;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed scenarios followed by random ops, each checked
// against an arithmetic model of HI/LO and the expected busy length.
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what HI/LO become and how long busy lasts, from the op's arithmetic meaning.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, output int n);
    longint      sa, sb, q, r;
    logic [63:0] p;
    n = 0;
    if (fl) return;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; n = MULT_N; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; n = MULT_N; end
      3'd2: begin
        n = DIV_N;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end
      end
      3'd3: begin
        n = DIV_N;
        if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic fl_run, input string tag);
    int cyc;
    int exp_n;
    @(negedge clk);
    start = 1'b1; flush = fl; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; flush = fl_run;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    flush = 1'b0;
    model(op, a, b, fl, exp_n);
    check({tag, " busy_cycles"}, 32'(cyc), 32'(exp_n));
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    int cyc;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_fl;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; md_op = 3'd7; src_a = '0; src_b = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1/2: signed vs unsigned multiply of the same operands
    do_op(3'd0, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "mult");
    check("mult hi const", hi, 32'hFFFFFFFF);
    check("mult lo const", lo, 32'hFFFFFFFE);
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "multu");
    check("multu hi const", hi, 32'h00000001);
    // 3: signed divide, then divide by zero keeps HI/LO
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div");
    check("div lo const", lo, 32'hFFFFFFFD);
    check("div hi const", hi, 32'hFFFFFFFF);
    do_op(3'd4, 32'h1234, 32'd0, 1'b0, 1'b0, "mthi1234");
    do_op(3'd5, 32'h1234, 32'd0, 1'b0, 1'b0, "mtlo1234");
    do_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0, "divu_by0");
    check("divu_by0 hi const", hi, 32'h1234);
    // overflow case and a flush held during RUN
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
    check("div_ovf lo const", lo, 32'h80000000);
    do_op(3'd0, 32'd12345, 32'hFFFF0000, 1'b0, 1'b1, "mult_flush_run");
    // 4: mthi leaves lo alone; start with flush does nothing
    do_op(3'd4, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0, "mthi");
    do_op(3'd0, 32'd99, 32'd77, 1'b1, 1'b0, "mult_flushed");

    // 5: second start while busy is dropped
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("ignore busy c1", 32'(busy), 32'd1);
    @(negedge clk);
    check("ignore busy c2", 32'(busy), 32'd1);
    start = 1'b1; md_op = 3'd3; src_a = 32'd2; src_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    check("ignore busy_cycles", 32'(cyc + 2), 32'(MULT_N));
    exp_hi = 32'd0; exp_lo = 32'd12;
    check("ignore hi", hi, exp_hi);
    check("ignore lo", lo, exp_lo);

    // 6: asynchronous reset mid-RUN discards the pending divide
    @(negedge clk);
    start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid hi", hi, 32'd0);
    check("rst_mid lo", lo, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DIV_N + 2) @(negedge clk);
    check("post_rst busy", 32'(busy), 32'd0);
    check("post_rst state", 32'(dbg_state), 32'd0);
    check("post_rst lo", lo, 32'd0);

    // random ops, with corner operands mixed in
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
        2: r_b = 32'($urandom_range(1, 9));
        3: r_b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      r_fl = ($urandom_range(0, 5) == 0);
      do_op(r_op, r_a, r_b, r_fl, 1'($urandom_range(0, 1)), $sformatf("rnd%0d op%0d", i, r_op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
